vector_dot_product_stream: RTL and testbench
============================================

# vector_dot_product_stream

Streaming, multi-lane dot-product engine over the Mersenne-31 field (p = 2^31 − 1). It accepts LANES element pairs per beat through a valid/ready handshake and multiplies them in parallel pipelined lanes. It accumulates the products mod p across an arbitrary number of beats, terminated by `in_last`. It then presents one canonical result on a valid/ready output. It is the successor to the fixed-size, free-running dot-product unit and is intended for matrix-vector datapaths where vector length is not known at elaboration.

## Interface
- `WORD_WIDTH`, 31: element width. Must be 31; any other value is an elaboration error.
- `LANES`, 4: element pairs consumed per beat. Must be ≥ 1.
- `MUL_STAGES`, 2: multiplier pipeline depth. Must be ≥ 1.
- `COUNT_WIDTH`, 16: width of the element counter.
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block can accept a beat.
- `in_a` in LANES×WORD_WIDTH: unpacked operand A, one element per lane.
- `in_b` in LANES×WORD_WIDTH: unpacked operand B, one element per lane.
- `in_mask` in LANES: lane enables. A disabled lane contributes 0 and is not counted.
- `in_last` in 1: marks the final beat of a vector.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out WORD_WIDTH: dot product mod p, canonical in [0, p−1].
- `out_count` out COUNT_WIDTH: number of enabled elements accumulated, modulo 2^COUNT_WIDTH.

## Operation
- **States**
  - RUN: `in_ready` = 1.
  - FLUSH: `in_ready` = 0; waits for the last beat to drain through the pipeline.
  - HOLD: `out_valid` = 1.
- **Transitions**
  - RUN → FLUSH on an accepted beat with `in_last` = 1.
  - FLUSH → HOLD after MUL_STAGES+2 edges, counted from the accepting edge.
  - HOLD → RUN on `out_valid && out_ready`. The accumulator and count clear on that same edge.
- A beat is accepted when `in_valid && in_ready`. Beats are accepted back to back in RUN, one per cycle.
- **Per lane** (pipelined, MUL_STAGES deep):
  - x = a·b, 62 bits.
  - s = x[30:0] + x[61:31].
  - r = s[30:0] + s[31].
  - If r == p, then r = 0.
  - Masked lanes force r = 0.
- **Lane sum:** reduction tree of modular adds, registered once. Modular add: t = u + v; if t ≥ p, then t −= p.
- **Accumulator:** acc ← acc ⊕ lane_sum (modular add); count ← count + popcount(mask). Both update only for beats that were accepted.
- Operand value 2^31−1 (≡ 0) is legal. Results are always canonical.
- In FLUSH and HOLD, input beats are not accepted. In-flight data already in the pipeline still completes.
- `out_result` and `out_count` stay stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- **Reset values:** `in_ready` = 0 while `reset` is asserted; `out_valid` = 0, `out_result` = 0, `out_count` = 0; state = RUN, accumulator = 0, pipeline valid bits = 0. `in_ready` = 1 from the first cycle after reset releases.
- **Latency:** the last beat is accepted at edge T; `out_valid` rises after edge T+MUL_STAGES+2. With the default MUL_STAGES = 2, this is 4 edges.
- **Throughput:** one beat per cycle within a vector. Between vectors there is a gap of MUL_STAGES+2 cycles plus the output wait.
- **Reset mid-operation:** all state clears immediately (asynchronously). Partial sums and in-flight products are discarded.
- **Empty vector:** a single beat with `in_last` = 1 and mask = 0 gives result 0, count 0, with normal latency.
- **Output handshake:** `out_ready` held high in HOLD means a one-cycle `out_valid` pulse. `in_ready` returns to 1 on the following cycle.

## Structure
- **Package `m31_pkg`:**
  - constant P = 31'h7FFF_FFFF
  - function `m31_add` (modular add)
  - function `m31_reduce62` (62-bit reduction)
  - state enum {RUN, FLUSH, HOLD}
- **Sub-module `m31_lane_mul`:** one lane (MUL_STAGES-deep multiply plus reduction, with a valid/mask sideband). Instantiated LANES times.
- The top level holds the FSM, the adder tree, the accumulator, the counter and the flush counter.

## Test plan
- **Single beat:** a={1,2,3,4}, b={5,6,7,8}, mask=4'hF, last → result 70, count 4. `out_valid` exactly 4 edges after acceptance.
- **Wrap-around:** every lane a=b=p−1 → (p−1)² ≡ 1 per lane; result 4. Also a lane with a=2^31−1 contributes 0.
- **Multi-beat with mask:**
  - beat 1: a={1,1,1,1}, b={2,2,2,2}, mask F
  - beat 2: a={3,3,3,3}, b={3,3,3,3}, mask 4'b0011, last
  - → result 26, count 6.
- **Backpressure:** `out_ready` = 0 for 10 cycles. Result and count stay stable, `in_ready` = 0, and a held `in_valid` is not accepted. After the release, the next vector {2}·{3} (mask 1, last) gives 6, not an accumulation on top of the previous result.
- **Reset mid-vector:** assert `reset` after 2 beats → outputs clear immediately. The next vector {1}·{1} (mask 1, last) gives 1, count 1.
- **Empty vector:** mask = 0, last → result 0, count 0, normal latency.

Source files
------------

// File: rtl/m31_pkg.sv
`default_nettype none
// ============================================================================
// m31_pkg : Mersenne-31 field constants, arithmetic helpers and FSM encoding
// Rev 1.0
// ============================================================================
package m31_pkg;

  localparam int W = 31;
  localparam logic [W-1:0] P = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [W-1:0] m31_add(input logic [W-1:0] u, input logic [W-1:0] v);
    logic [W:0] t;
    t = {1'b0, u} + {1'b0, v};
    if (t >= {1'b0, P}) t = t - {1'b0, P};
    return t[W-1:0];
  endfunction

  // 2^31 == 1 (mod p): fold the high half onto the low half twice.
  function automatic logic [W-1:0] m31_reduce62(input logic [2*W-1:0] x);
    logic [W:0]   s;
    logic [W-1:0] r;
    s = {1'b0, x[W-1:0]} + {1'b0, x[2*W-1:W]};
    r = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    if (r == P) r = '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_dot_product_stream_if.sv
`default_nettype none
// ============================================================================
// vector_dot_product_stream_if : beat input and result output handshakes
// Rev 1.0
// ============================================================================
interface vector_dot_product_stream_if #(
  parameter int WORD_WIDTH  = 31,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_WIDTH-1:0]  in_a [LANES];
  logic [WORD_WIDTH-1:0]  in_b [LANES];
  logic [LANES-1:0]       in_mask;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  out_result;
  logic [COUNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count
  );
endinterface
`default_nettype wire

// File: rtl/m31_lane_mul.sv
`default_nettype none
// ============================================================================
// m31_lane_mul : one pipelined Mersenne-31 multiplier lane with valid/mask
// Rev 1.0
// ============================================================================
module m31_lane_mul
  import m31_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         in_valid,
  input  wire logic         in_mask,
  input  wire logic [W-1:0] in_a,
  input  wire logic [W-1:0] in_b,
  output logic              out_valid,
  output logic [W-1:0]      out_r
);

  logic [2*W-1:0]        w_prod;
  logic [2*W-1:0]        r_x [MUL_STAGES];
  logic [MUL_STAGES-1:0] r_v;
  logic [MUL_STAGES-1:0] r_m;

  assign w_prod = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_STAGES; k++) r_x[k] <= '0;
      r_v <= '0;
      r_m <= '0;
    end else begin
      r_x[0] <= w_prod;
      r_v[0] <= in_valid;
      r_m[0] <= in_mask;
      for (int k = 1; k < MUL_STAGES; k++) begin
        r_x[k] <= r_x[k-1];
        r_v[k] <= r_v[k-1];
        r_m[k] <= r_m[k-1];
      end
    end
  end

  assign out_valid = r_v[MUL_STAGES-1];
  assign out_r     = (r_v[MUL_STAGES-1] && r_m[MUL_STAGES-1]) ?
                     m31_reduce62(r_x[MUL_STAGES-1]) : '0;

endmodule
`default_nettype wire

// File: rtl/vector_dot_product_stream.sv
`default_nettype none
// ============================================================================
// vector_dot_product_stream : streaming multi-lane dot product mod 2^31-1
// Rev 1.0
// ============================================================================
module vector_dot_product_stream
  import m31_pkg::*;
#(
  parameter int WORD_WIDTH  = 31,
  parameter int LANES       = 4,
  parameter int MUL_STAGES  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  vector_dot_product_stream_if.slave  bus
);

  localparam logic [1:0] c_st_run       = RUN;
  localparam logic [1:0] c_st_flush     = FLUSH;
  localparam logic [1:0] c_st_hold      = HOLD;
  localparam int         c_flush_cycles = MUL_STAGES + 2;
  localparam int         c_flush_w      = $clog2(c_flush_cycles + 1);
  localparam int         c_tree_w       = 1 << $clog2(LANES);

  if (WORD_WIDTH != 31) begin : g_chk_width
    $error("WORD_WIDTH must be 31");
  end
  if (LANES < 1) begin : g_chk_lanes
    $error("LANES must be at least 1");
  end
  if (MUL_STAGES < 1) begin : g_chk_stages
    $error("MUL_STAGES must be at least 1");
  end

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [LANES-1:0] m);
    logic [COUNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + COUNT_WIDTH'(m[i]);
    return c;
  endfunction

  logic [1:0]             r_state;
  logic [c_flush_w-1:0]   r_flush;
  logic [WORD_WIDTH-1:0]  r_sum;
  logic                   r_sum_valid;
  logic [WORD_WIDTH-1:0]  r_acc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_accept;
  logic                   w_out_fire;
  logic [WORD_WIDTH-1:0]  w_lane_r [LANES];
  logic [LANES-1:0]       w_lane_valid;
  logic [WORD_WIDTH-1:0]  w_lane_sum;

  // Gated by reset so no beat is offered while state is being cleared.
  assign bus.in_ready   = (r_state == c_st_run) && !reset;
  assign bus.out_valid  = (r_state == c_st_hold);
  assign bus.out_result = r_acc;
  assign bus.out_count  = r_count;
  assign w_accept       = bus.in_valid && bus.in_ready;
  assign w_out_fire     = bus.out_valid && bus.out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    m31_lane_mul #(
      .MUL_STAGES(MUL_STAGES)
    ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_accept),
      .in_mask   (bus.in_mask[i]),
      .in_a      (bus.in_a[i]),
      .in_b      (bus.in_b[i]),
      .out_valid (w_lane_valid[i]),
      .out_r     (w_lane_r[i])
    );
  end

  // Pairwise tree over a power-of-two padded node array.
  always_comb begin
    logic [WORD_WIDTH-1:0] node [c_tree_w];
    for (int i = 0; i < LANES; i++) node[i] = w_lane_r[i];
    for (int i = LANES; i < c_tree_w; i++) node[i] = '0;
    for (int span = 1; span < c_tree_w; span = span * 2) begin
      for (int i = 0; i + span < c_tree_w; i = i + 2 * span) begin
        node[i] = m31_add(node[i], node[i+span]);
      end
    end
    w_lane_sum = node[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
    end else begin
      r_sum       <= w_lane_sum;
      r_sum_valid <= |w_lane_valid;
      if (w_out_fire)       r_acc <= '0;
      else if (r_sum_valid) r_acc <= m31_add(r_acc, r_sum);
      if (w_out_fire)       r_count <= '0;
      else if (w_accept)    r_count <= r_count + popcount(bus.in_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_run;
      r_flush <= '0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (w_accept && bus.in_last) begin
            r_state <= c_st_flush;
            r_flush <= c_flush_w'(c_flush_cycles - 1);
          end
        end
        c_st_flush: begin
          if (r_flush == '0) r_state <= c_st_hold;
          else               r_flush <= r_flush - c_flush_w'(1);
        end
        c_st_hold: begin
          if (w_out_fire) r_state <= c_st_run;
        end
        default: r_state <= c_st_run;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_dot_product_stream.sv
`default_nettype none
// ============================================================================
// tb_vector_dot_product_stream : directed self-checking bench
// Rev 1.0
// ============================================================================
module tb_vector_dot_product_stream;

  localparam int         c_lanes = 4;
  localparam int         c_ww    = 31;
  localparam int         c_ms    = 2;
  localparam int         c_cw    = 16;
  localparam logic [30:0] c_p    = 31'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vector_dot_product_stream_if #(
    .WORD_WIDTH(c_ww), .LANES(c_lanes), .COUNT_WIDTH(c_cw)
  ) bus ();

  vector_dot_product_stream #(
    .WORD_WIDTH(c_ww), .LANES(c_lanes), .MUL_STAGES(c_ms), .COUNT_WIDTH(c_cw)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input logic [30:0] a0, a1, a2, a3, b0, b1, b2, b3,
                          input logic [3:0] mask, input logic last);
    bus.in_a[0] = a0; bus.in_a[1] = a1; bus.in_a[2] = a2; bus.in_a[3] = a3;
    bus.in_b[0] = b0; bus.in_b[1] = b1; bus.in_b[2] = b2; bus.in_b[3] = b3;
    bus.in_mask  = mask;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  task automatic accept();
    bit done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [30:0] er,
                               input logic [15:0] ec, input bit consume);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd4);
    check({tag, "_res"}, 64'(bus.out_result), 64'(er));
    check({tag, "_cnt"}, 64'(bus.out_count), 64'(ec));
    if (consume) begin
      @(posedge clk); #1;
      check({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_ir_back"}, 64'(bus.in_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < c_lanes; i++) begin
      bus.in_a[i] = '0;
      bus.in_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),   64'd0);
    check("rst_out_valid", 64'(bus.out_valid),  64'd0);
    check("rst_result",    64'(bus.out_result), 64'd0);
    check("rst_count",     64'(bus.out_count),  64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1*5+2*6+3*7+4*8 = 70
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 4'hF, 1'b1);
    accept();
    expect_result("single", 31'd70, 16'd4, 1'b1);

    // (p-1)^2 == 1 per lane
    set_beat(c_p - 1, c_p - 1, c_p - 1, c_p - 1, c_p - 1, c_p - 1, c_p - 1, c_p - 1, 4'hF, 1'b1);
    accept();
    expect_result("wrap_sq", 31'd4, 16'd4, 1'b1);

    // 4*(p-1) mod p = p-4 exercises the tree wrap
    set_beat(c_p - 1, c_p - 1, c_p - 1, c_p - 1, 1, 1, 1, 1, 4'hF, 1'b1);
    accept();
    expect_result("wrap_add", c_p - 31'd4, 16'd4, 1'b1);

    // p*9 and p*p both reduce to exactly p -> 0; only 3*4 survives
    set_beat(c_p, c_p, 3, 0, 9, c_p, 4, 5, 4'hF, 1'b1);
    accept();
    expect_result("op_p", 31'd12, 16'd4, 1'b1);

    // 4*2 + 2*9 = 26, count 6
    set_beat(1, 1, 1, 1, 2, 2, 2, 2, 4'hF, 1'b0);
    accept();
    set_beat(3, 3, 3, 3, 3, 3, 3, 3, 4'b0011, 1'b1);
    accept();
    expect_result("multi", 31'd26, 16'd6, 1'b1);

    bus.out_ready = 1'b0;
    set_beat(10, 0, 0, 0, 10, 0, 0, 0, 4'b0001, 1'b1);
    accept();
    expect_result("bp", 31'd100, 16'd1, 1'b0);
    set_beat(2, 0, 0, 0, 3, 0, 0, 0, 4'b0001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", 64'(bus.out_result), 64'd100);
      check("bp_hold_cnt", 64'(bus.out_count),  64'd1);
      check("bp_hold_ov",  64'(bus.out_valid),  64'd1);
      check("bp_hold_ir",  64'(bus.in_ready),   64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", 64'(bus.out_valid), 64'd0);
    accept();
    expect_result("after_bp", 31'd6, 16'd1, 1'b1);

    set_beat(1, 1, 1, 1, 2, 2, 2, 2, 4'hF, 1'b0);
    accept();
    set_beat(1, 1, 1, 1, 2, 2, 2, 2, 4'hF, 1'b0);
    accept();
    repeat (4) @(posedge clk);
    #1;
    check("mid_cnt_pre", 64'(bus.out_count), 64'd8);
    reset = 1'b1;
    #1;
    check("mid_rst_ov",  64'(bus.out_valid),  64'd0);
    check("mid_rst_res", 64'(bus.out_result), 64'd0);
    check("mid_rst_cnt", 64'(bus.out_count),  64'd0);
    check("mid_rst_ir",  64'(bus.in_ready),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    set_beat(1, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 1'b1);
    accept();
    expect_result("after_rst", 31'd1, 16'd1, 1'b1);

    set_beat(5, 6, 7, 8, 1, 1, 1, 1, 4'b0000, 1'b1);
    accept();
    expect_result("empty", 31'd0, 16'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
